// File: rtl/pulse_burst_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_burst_gen_if
// Brief    : Trigger / burst-status bundle between the delay stage and the
//            burst generator.
// Revision : 1.0
// ============================================================================
interface pulse_burst_gen_if #(
    parameter int N_W = 8
);
    logic           trig;
    logic [N_W-1:0] n_req;
    logic           dout;
    logic           busy;
    logic           done;
    logic           retrig;

    modport master (
        output trig,
        output n_req,
        input  dout,
        input  busy,
        input  done,
        input  retrig
    );

    modport slave (
        input  trig,
        input  n_req,
        output dout,
        output busy,
        output done,
        output retrig
    );
endinterface
`default_nettype wire

// File: rtl/pulse_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : pulse_burst_gen
// Brief    : Turns each accepted trigger into n_req pulses of WIDTH_CYC high
//            cycles repeating every PERIOD_CYC cycles; reports busy/done/retrig.
// Revision : 1.0
// ============================================================================
module pulse_burst_gen #(
    parameter int WIDTH_CYC  = 50,
    parameter int PERIOD_CYC = 100,
    parameter int N_W        = 8,
    parameter int CNT_W      = 32
) (
    input  wire logic         clk_pbg,
    input  wire logic         rst,
    pulse_burst_gen_if.slave  bus
);

    generate
        if (WIDTH_CYC < 1 || PERIOD_CYC <= WIDTH_CYC) begin : g_bad_params
            $error("pulse_burst_gen: need WIDTH_CYC >= 1 and PERIOD_CYC > WIDTH_CYC");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_w_last = CNT_W'(WIDTH_CYC - 1);
    localparam logic [CNT_W-1:0] c_p_last = CNT_W'(PERIOD_CYC - 1);
    localparam logic [N_W-1:0]   c_one    = N_W'(1);
    localparam logic [N_W-1:0]   c_zero   = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_phase;
    logic [N_W-1:0]   r_rem;
    logic             r_dout;
    logic             r_busy;
    logic             r_done;
    logic             r_retrig;

    logic w_pulse_end;
    logic w_last_end;

    // The phase counter runs 0..PERIOD_CYC-1 across one HIGH+LOW period.
    assign w_pulse_end = (r_state == ST_HIGH) && (r_phase == c_w_last);
    assign w_last_end  = w_pulse_end && (r_rem == c_one);

    always_ff @(posedge clk_pbg or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_phase  <= '0;
            r_rem    <= '0;
            r_dout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_retrig <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_retrig <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.trig) begin
                        if (bus.n_req != c_zero) begin
                            r_rem   <= bus.n_req;
                            r_phase <= '0;
                            r_dout  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= ST_HIGH;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (w_last_end) begin
                        // The completing edge behaves as idle: a trig here starts a new burst.
                        r_done  <= 1'b1;
                        r_phase <= '0;
                        if (bus.trig && (bus.n_req != c_zero)) begin
                            r_rem   <= bus.n_req;
                            r_dout  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= ST_HIGH;
                        end else begin
                            r_rem   <= '0;
                            r_dout  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_retrig <= bus.trig;
                        r_phase  <= r_phase + 1'b1;
                        if (w_pulse_end) begin
                            r_rem   <= r_rem - c_one;
                            r_dout  <= 1'b0;
                            r_state <= ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    r_retrig <= bus.trig;
                    if (r_phase == c_p_last) begin
                        r_phase <= '0;
                        r_dout  <= 1'b1;
                        r_state <= ST_HIGH;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_dout  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout   = r_dout;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.retrig = r_retrig;

endmodule
`default_nettype wire

// File: tb/tb_pulse_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_burst_gen
// Brief    : Self-checking bench for pulse_burst_gen against a burst-timing model.
// Revision : 1.0
// ============================================================================
module tb_pulse_burst_gen;

    localparam int W   = 3;
    localparam int P   = 5;
    localparam int NW  = 8;

    logic clk_pbg = 1'b0;
    logic rst     = 1'b1;

    pulse_burst_gen_if #(.N_W(NW)) bus ();

    pulse_burst_gen #(
        .WIDTH_CYC  (W),
        .PERIOD_CYC (P),
        .N_W        (NW),
        .CNT_W      (32)
    ) dut (
        .clk_pbg (clk_pbg),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_pbg = ~clk_pbg;

    int checks   = 0;
    int failures = 0;

    // Model state: the current burst is described by its start edge and pulse count.
    int cyc     = 0;
    bit active  = 1'b0;
    int b_start = 0;
    int b_n     = 0;
    bit e_dout, e_busy, e_done, e_retrig;

    task automatic model_reset();
        active   = 1'b0;
        e_dout   = 1'b0;
        e_busy   = 1'b0;
        e_done   = 1'b0;
        e_retrig = 1'b0;
    endtask

    task automatic model_edge(input bit t, input int n);
        int fin;
        cyc++;
        e_done   = 1'b0;
        e_retrig = 1'b0;
        fin = b_start + (b_n - 1) * P + W;
        if (active && cyc < fin) begin
            if (t) e_retrig = 1'b1;
        end else begin
            if (active) begin
                e_done = 1'b1;
                active = 1'b0;
            end
            if (t) begin
                if (n != 0) begin
                    active  = 1'b1;
                    b_start = cyc;
                    b_n     = n;
                end else begin
                    e_done = 1'b1;
                end
            end
        end
        fin    = b_start + (b_n - 1) * P + W;
        e_busy = active && (cyc < fin);
        e_dout = e_busy && (((cyc - b_start) % P) < W);
    endtask

    // Drive inputs at the falling edge, clock once, advance the model, sample 2ns after the edge.
    task automatic step(input bit t, input int n);
        #3;
        bus.trig  = t;
        bus.n_req = NW'(n);
        @(posedge clk_pbg);
        #2;
        model_edge(t, n);
        bus.trig = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.trig  = 1'b0;
        bus.n_req = '0;
        model_reset();
        repeat (3) @(posedge clk_pbg);
        #2;
        checks++;
        if ({bus.dout, bus.busy, bus.done, bus.retrig} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=0000", {bus.dout, bus.busy, bus.done, bus.retrig});
        end
        #4 rst = 1'b0;
        @(posedge clk_pbg);
        #2;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 0);
            checks++;
            if ({bus.dout, bus.busy, bus.done, bus.retrig} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_idle i=%0d got=%b exp=0000", i, {bus.dout, bus.busy, bus.done, bus.retrig});
            end
        end
    endtask

    task automatic test_two_pulses();
        int highs;
        int dones;
        highs = 0;
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            step(c == 10, 2);
            highs += int'(bus.dout);
            dones += int'(bus.done);
            checks++;
            if ({bus.dout, bus.busy, bus.done, bus.retrig} !== {e_dout, e_busy, e_done, e_retrig}) begin
                failures++;
                $display("FAIL two_pulses c=%0d got=%b exp=%b", c,
                         {bus.dout, bus.busy, bus.done, bus.retrig}, {e_dout, e_busy, e_done, e_retrig});
            end
            if (c == 18) begin
                checks++;
                if (bus.done !== 1'b1) begin
                    failures++;
                    $display("FAIL two_pulses_done18 got=%b exp=1", bus.done);
                end
            end
        end
        checks++;
        if (highs != 2 * W || dones != 1) begin
            failures++;
            $display("FAIL two_pulses_totals highs=%0d dones=%0d exp=%0d/1", highs, dones, 2 * W);
        end
    endtask

    task automatic test_retrig();
        int rts;
        rts = 0;
        for (int c = 0; c < 30; c++) begin
            // n_req wanders during the burst; only the accepted-edge value matters.
            step(c == 10 || c == 12 || c == 22, (c == 10) ? 3 : int'($urandom_range(0, 9)));
            rts += int'(bus.retrig);
            checks++;
            if ({bus.dout, bus.busy, bus.done, bus.retrig} !== {e_dout, e_busy, e_done, e_retrig}) begin
                failures++;
                $display("FAIL retrig c=%0d got=%b exp=%b", c,
                         {bus.dout, bus.busy, bus.done, bus.retrig}, {e_dout, e_busy, e_done, e_retrig});
            end
        end
        checks++;
        if (rts != 2) begin
            failures++;
            $display("FAIL retrig_count got=%0d exp=2", rts);
        end
    endtask

    task automatic test_zero_req();
        for (int c = 0; c < 10; c++) begin
            step(c == 5, 0);
            checks++;
            if ({bus.dout, bus.busy, bus.done, bus.retrig} !== {e_dout, e_busy, e_done, e_retrig}) begin
                failures++;
                $display("FAIL zero_req c=%0d got=%b exp=%b", c,
                         {bus.dout, bus.busy, bus.done, bus.retrig}, {e_dout, e_busy, e_done, e_retrig});
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int dones;
        dones = 0;
        for (int c = 0; c <= 7; c++) step(c == 0, 4);
        #1 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({bus.dout, bus.busy, bus.done, bus.retrig} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset got=%b exp=0000", {bus.dout, bus.busy, bus.done, bus.retrig});
        end
        #2 rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            step(c == 2, 4);
            dones += int'(bus.done);
            checks++;
            if ({bus.dout, bus.busy, bus.done, bus.retrig} !== {e_dout, e_busy, e_done, e_retrig}) begin
                failures++;
                $display("FAIL after_reset c=%0d got=%b exp=%b", c,
                         {bus.dout, bus.busy, bus.done, bus.retrig}, {e_dout, e_busy, e_done, e_retrig});
            end
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL after_reset_done got=%0d exp=1", dones);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 10; c++) begin
            step(c == 0 || c == 3, 1);
            checks++;
            if ({bus.dout, bus.busy, bus.done, bus.retrig} !== {e_dout, e_busy, e_done, e_retrig}) begin
                failures++;
                $display("FAIL back_to_back c=%0d got=%b exp=%b", c,
                         {bus.dout, bus.busy, bus.done, bus.retrig}, {e_dout, e_busy, e_done, e_retrig});
            end
            if (c >= 3 && c <= 5) begin
                checks++;
                if (bus.dout !== 1'b1) begin
                    failures++;
                    $display("FAIL back_to_back_dout c=%0d got=%b exp=1", c, bus.dout);
                end
            end
        end
    endtask

    task automatic test_max_count();
        int dones;
        int rises;
        bit prev;
        dones = 0;
        rises = 0;
        prev  = 1'b0;
        for (int c = 0; c < 255 * P + 10; c++) begin
            step(c == 1, 255);
            dones += int'(bus.done);
            rises += int'(bus.dout && !prev);
            prev   = bus.dout;
            checks++;
            if ({bus.dout, bus.busy, bus.done, bus.retrig} !== {e_dout, e_busy, e_done, e_retrig}) begin
                failures++;
                $display("FAIL max_count c=%0d got=%b exp=%b", c,
                         {bus.dout, bus.busy, bus.done, bus.retrig}, {e_dout, e_busy, e_done, e_retrig});
            end
        end
        checks++;
        if (rises != 255 || dones != 1) begin
            failures++;
            $display("FAIL max_count_totals rises=%0d dones=%0d exp=255/1", rises, dones);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 7) == 0, int'($urandom_range(0, 5)));
            checks++;
            if ({bus.dout, bus.busy, bus.done, bus.retrig} !== {e_dout, e_busy, e_done, e_retrig}) begin
                failures++;
                $display("FAIL random c=%0d got=%b exp=%b", c,
                         {bus.dout, bus.busy, bus.done, bus.retrig}, {e_dout, e_busy, e_done, e_retrig});
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_pulses();
        test_retrig();
        test_zero_req();
        test_reset_mid_burst();
        for (int i = 0; i < 5; i++) step(1'b0, 0);
        test_back_to_back();
        for (int i = 0; i < 5; i++) step(1'b0, 0);
        test_max_count();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
